// File: rtl/multiport_register_file.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : multiport_register_file                                       |
// | Purpose  : Parametrised CPU register file. Asynchronous reads on NUM_RD  |
// |            ports, one clocked write port with full / upper-immediate /   |
// |            lower-merge modes, optional hardwired zero entry, and a       |
// |            sequential clear sweep after reset or on a clr pulse.         |
// | Ports    : clk   - clock, all state changes on the rising edge           |
// |            rst   - synchronous active-high reset (starts a clear sweep)  |
// |            clr   - one-cycle pulse, starts a clear sweep from RUN        |
// |            raddr - NUM_RD packed read addresses, port p at [p*ADDR_W +:] |
// |            rdata - NUM_RD packed read data, port p at [p*DATA_W +:]      |
// |            waddr - write address                                         |
// |            wdata - write data                                            |
// |            wren  - write enable                                          |
// |            wmode - 00 full, 01 upper immediate, 10 lower merge, 11 full  |
// |            ready - high while in RUN (writes accepted)                   |
// | Options  : define RF_BYPASS_EN to forward the written value to read      |
// |            ports addressing waddr in the same cycle.                     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+

module multiport_register_file #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     wren,
    input  logic [1:0]               wmode,
    output logic                     ready
);

    localparam int              c_DEPTH    = 2 ** ADDR_W;
    localparam int              c_HALF     = DATA_W / 2;
    localparam logic [ADDR_W-1:0] c_CNT_LAST = {ADDR_W{1'b1}};

    localparam logic [0:0] c_ST_CLEAR = 1'b0;
    localparam logic [0:0] c_ST_RUN   = 1'b1;

    logic [DATA_W-1:0] r_mem [c_DEPTH];
    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic              w_sweep_we;
    logic              w_user_we;
    logic              w_zero_drop;
    logic [DATA_W-1:0] w_wval;

    assign ready       = (r_state == c_ST_RUN);
    assign w_zero_drop = (ZERO_REG != 0) && (waddr == '0);

    // Value that a write would store; mode 10 keeps the entry's upper half.
    always_comb begin
        w_wval = wdata;
        case (wmode)
            2'b01:   w_wval = {wdata[c_HALF-1:0], {c_HALF{1'b0}}};
            2'b10:   w_wval = {r_mem[waddr][DATA_W-1:c_HALF], wdata[c_HALF-1:0]};
            default: w_wval = wdata;
        endcase
    end

    // Next-state logic. clr outranks a write presented on the same edge.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sweep_we  = 1'b0;
        w_user_we   = 1'b0;
        case (r_state)
            c_ST_CLEAR: begin
                w_sweep_we = 1'b1;
                w_cnt_nxt  = r_cnt + ADDR_W'(1);
                if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (clr) begin
                    w_state_nxt = c_ST_CLEAR;
                    w_cnt_nxt   = '0;
                end else if (wren && !w_zero_drop) begin
                    w_user_we = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_ST_CLEAR;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Storage is never reset directly; the sweep zeroes it one entry per edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_sweep_we) begin
                r_mem[r_cnt] <= '0;
            end else if (w_user_we) begin
                r_mem[waddr] <= w_wval;
            end
        end
    end

    generate
        for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
            logic [ADDR_W-1:0] w_ra;
            logic [DATA_W-1:0] w_rd;

            assign w_ra = raddr[p*ADDR_W +: ADDR_W];

            always_comb begin
                w_rd = '0;
                if ((r_state == c_ST_RUN) && !((ZERO_REG != 0) && (w_ra == '0))) begin
                    w_rd = r_mem[w_ra];
`ifdef RF_BYPASS_EN
                    // Forward the post-mode value; a pending clr suppresses it.
                    if (wren && !clr && (w_ra == waddr)) begin
                        w_rd = w_wval;
                    end
`endif
                end
            end

            assign rdata[p*DATA_W +: DATA_W] = w_rd;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_multiport_register_file.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_multiport_register_file                                    |
// | Purpose  : Directed self-checking bench. u0 uses defaults (2 ports, zero |
// |            register); u1 uses 4 ports without a zero register. Expected  |
// |            values follow RF_BYPASS_EN when it is defined.                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+

module tb_multiport_register_file;

    logic        clk = 1'b0;
    logic        r_rst = 1'b1;
    logic        r_clr = 1'b0;

    logic [9:0]  r_raddr0 = '0;
    logic [63:0] w_rdata0;
    logic [4:0]  r_waddr0 = '0;
    logic [31:0] r_wdata0 = '0;
    logic        r_wren0 = 1'b0;
    logic [1:0]  r_wmode0 = 2'b00;
    logic        w_ready0;

    logic [19:0]  r_raddr1 = '0;
    logic [127:0] w_rdata1;
    logic [4:0]   r_waddr1 = '0;
    logic [31:0]  r_wdata1 = '0;
    logic         r_wren1 = 1'b0;
    logic [1:0]   r_wmode1 = 2'b00;
    logic         w_ready1;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef RF_BYPASS_EN
    localparam bit c_BYP = 1'b1;
`else
    localparam bit c_BYP = 1'b0;
`endif

    always #5 clk = ~clk;

    multiport_register_file #(
        .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)
    ) u0 (
        .clk(clk), .rst(r_rst), .clr(r_clr),
        .raddr(r_raddr0), .rdata(w_rdata0),
        .waddr(r_waddr0), .wdata(r_wdata0), .wren(r_wren0), .wmode(r_wmode0),
        .ready(w_ready0)
    );

    multiport_register_file #(
        .DATA_W(32), .ADDR_W(5), .NUM_RD(4), .ZERO_REG(0)
    ) u1 (
        .clk(clk), .rst(r_rst), .clr(r_clr),
        .raddr(r_raddr1), .rdata(w_rdata1),
        .waddr(r_waddr1), .wdata(r_wdata1), .wren(r_wren1), .wmode(r_wmode1),
        .ready(w_ready1)
    );

    typedef struct {
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [1:0]  wmode;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } vec_t;

    vec_t vecs [11];

    function automatic logic [31:0] rd0(input int p);
        return w_rdata0[p*32 +: 32];
    endfunction

    function automatic logic [31:0] rd1(input int p);
        return w_rdata1[p*32 +: 32];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a falling edge: checks ready=0 and port0 reads 0 before each
    // of n rising edges, then checks ready=1 after the last one.
    task automatic sweep_check(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            #1;
            chk({tag, "_ready_low"}, {31'd0, w_ready0}, 32'd0);
            chk({tag, "_rdata_zero"}, rd0(0), 32'd0);
            @(negedge clk);
        end
        #1;
        chk({tag, "_ready_high"}, {31'd0, w_ready0}, 32'd1);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 5'd5,  32'h1234_5678, 2'b00, 5'd5,  5'd0,  32'h1234_5678, 32'h0};
        vecs[1]  = '{1'b1, 5'd5,  32'h0000_ABCD, 2'b10, 5'd5,  5'd5,  32'h1234_ABCD, 32'h1234_ABCD};
        vecs[2]  = '{1'b1, 5'd6,  32'h0000_00FF, 2'b01, 5'd6,  5'd5,  32'h00FF_0000, 32'h1234_ABCD};
        vecs[3]  = '{1'b1, 5'd7,  32'h0000_0001, 2'b11, 5'd7,  5'd6,  32'h0000_0001, 32'h00FF_0000};
        vecs[4]  = '{1'b1, 5'd0,  32'hFFFF_FFFF, 2'b00, 5'd0,  5'd0,  32'h0,         32'h0};
        vecs[5]  = '{1'b1, 5'd9,  32'h0000_0011, 2'b00, 5'd9,  5'd3,  32'h0000_0011, 32'hDEAD_BEEF};
        vecs[6]  = '{1'b1, 5'd10, 32'hABCD_1234, 2'b01, 5'd10, 5'd9,  32'h1234_0000, 32'h0000_0011};
        vecs[7]  = '{1'b1, 5'd10, 32'hFFFF_5678, 2'b10, 5'd10, 5'd10, 32'h1234_5678, 32'h1234_5678};
        vecs[8]  = '{1'b0, 5'd11, 32'hDEAD_BEEF, 2'b00, 5'd11, 5'd7,  32'h0,         32'h0000_0001};
        vecs[9]  = '{1'b1, 5'd31, 32'hCAFE_F00D, 2'b00, 5'd31, 5'd30, 32'hCAFE_F00D, 32'h0};
        vecs[10] = '{1'b1, 5'd4,  32'h0000_0077, 2'b00, 5'd4,  5'd3,  32'h0000_0077, 32'hDEAD_BEEF};

        // Reset, then a write held during the whole sweep.
        repeat (3) @(negedge clk);
        #1;
        chk("reset_ready", {31'd0, w_ready0}, 32'd0);
        @(negedge clk);
        r_rst    = 1'b0;
        r_wren0  = 1'b1;
        r_waddr0 = 5'd3;
        r_wdata0 = 32'hDEAD_BEEF;
        r_wmode0 = 2'b00;
        r_raddr0 = {5'd0, 5'd3};
        sweep_check(32, "reset_sweep");
        chk("reset_u1_ready", {31'd0, w_ready1}, 32'd1);
        chk("reset_r3_before_write", rd0(0), c_BYP ? 32'hDEAD_BEEF : 32'h0);
        @(negedge clk);
        r_wren0 = 1'b0;
        #1;
        chk("reset_r3_after_write", rd0(0), 32'hDEAD_BEEF);

        // Table-driven writes and read-backs on the default instance.
        foreach (vecs[i]) begin
            @(negedge clk);
            r_wren0  = vecs[i].wen;
            r_waddr0 = vecs[i].waddr;
            r_wdata0 = vecs[i].wdata;
            r_wmode0 = vecs[i].wmode;
            r_raddr0 = {vecs[i].ra1, vecs[i].ra0};
            @(negedge clk);
            r_wren0 = 1'b0;
            #1;
            chk($sformatf("vec%0d_port0", i), rd0(0), vecs[i].exp0);
            chk($sformatf("vec%0d_port1", i), rd0(1), vecs[i].exp1);
        end

        // Same-cycle read of the address being written.
        @(negedge clk);
        r_wren0 = 1'b1; r_waddr0 = 5'd9; r_wdata0 = 32'h22; r_wmode0 = 2'b00;
        r_raddr0 = {5'd0, 5'd9};
        #1;
        chk("samecyc_r9", rd0(0), c_BYP ? 32'h22 : 32'h11);
        chk("samecyc_port1_zero", rd0(1), 32'h0);
        @(negedge clk);
        r_wren0 = 1'b0;
        #1;
        chk("samecyc_r9_next", rd0(0), 32'h22);

        @(negedge clk);
        r_wren0 = 1'b1; r_waddr0 = 5'd5; r_wdata0 = 32'hFFFF_9999; r_wmode0 = 2'b10;
        r_raddr0 = {5'd5, 5'd5};
        #1;
        chk("samecyc_merge", rd0(0), c_BYP ? 32'h1234_9999 : 32'h1234_ABCD);
        @(negedge clk);
        r_wren0 = 1'b0;
        #1;
        chk("samecyc_merge_next", rd0(1), 32'h1234_9999);

        @(negedge clk);
        r_wren0 = 1'b1; r_waddr0 = 5'd0; r_wdata0 = 32'hFFFF_FFFF; r_wmode0 = 2'b00;
        r_raddr0 = {5'd0, 5'd0};
        #1;
        chk("samecyc_zero_reg", rd0(0), 32'h0);
        @(negedge clk);
        r_wren0 = 1'b0;
        #1;
        chk("samecyc_zero_reg_next", rd0(1), 32'h0);

        // Four-port instance without a zero register.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            r_wren1  = 1'b1;
            r_waddr1 = 5'(k);
            r_wdata1 = (k == 0) ? 32'hFFFF_FFFF : 32'h1111_1111 * k;
            r_wmode1 = 2'b00;
        end
        @(negedge clk);
        r_wren1  = 1'b0;
        r_raddr1 = {5'd4, 5'd3, 5'd2, 5'd1};
        #1;
        chk("mp_port0_r1", rd1(0), 32'h1111_1111);
        chk("mp_port1_r2", rd1(1), 32'h2222_2222);
        chk("mp_port2_r3", rd1(2), 32'h3333_3333);
        chk("mp_port3_r4", rd1(3), 32'h4444_4444);
        r_raddr1 = {5'd2, 5'd2, 5'd2, 5'd2};
        #1;
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("mp_same_addr_port%0d", p), rd1(p), 32'h2222_2222);
        end
        r_raddr1 = {5'd0, 5'd0, 5'd0, 5'd0};
        #1;
        chk("mp_no_zero_reg", rd1(0), 32'hFFFF_FFFF);

        // clr with a simultaneous write: write dropped, full sweep follows.
        @(negedge clk);
        r_clr = 1'b1; r_wren0 = 1'b1; r_waddr0 = 5'd4; r_wdata0 = 32'h55; r_wmode0 = 2'b00;
        r_raddr0 = {5'd0, 5'd4};
        #1;
        chk("clr_no_bypass", rd0(0), 32'h77);
        chk("clr_ready_before", {31'd0, w_ready0}, 32'd1);
        @(negedge clk);
        r_clr = 1'b0; r_wren0 = 1'b0;
        r_raddr0 = {5'd4, 5'd31};
        sweep_check(32, "clr_sweep");
        chk("clr_r4_cleared", rd0(1), 32'h0);
        chk("clr_r31_cleared", rd0(0), 32'h0);
        r_raddr0 = {5'd5, 5'd9};
        r_raddr1 = {5'd4, 5'd3, 5'd2, 5'd1};
        #1;
        chk("clr_r9_cleared", rd0(0), 32'h0);
        chk("clr_r5_cleared", rd0(1), 32'h0);
        chk("clr_u1_ready", {31'd0, w_ready1}, 32'd1);
        chk("clr_u1_r1_cleared", rd1(0), 32'h0);

        // rst in the middle of a sweep restarts it from entry 0.
        @(negedge clk);
        r_clr = 1'b1;
        @(negedge clk);
        r_clr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("midrst_pre_ready_low", {31'd0, w_ready0}, 32'd0);
            @(negedge clk);
        end
        r_rst = 1'b1;
        @(negedge clk);
        r_rst = 1'b0;
        sweep_check(32, "midrst_sweep");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
